// File: rtl/udp_pkg.sv
// Shared UDP framing constants, default ports and scheduler state encoding.
// Also used by the UDP sender so both sides agree on header size and limits.
package udp_pkg;

    localparam int UDP_HDR_LEN      = 8;
    localparam int UDP_MAX_PAYLOAD  = 1472;
    localparam int UDP_DEF_SRC_PORT = 5000;
    localparam int UDP_DEF_DST0     = 5001;
    localparam int UDP_DEF_DST1     = 5002;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_SEND,
        ST_GAP
    } tx_state_e;

    function automatic logic [15:0] udp_len(input logic [10:0] payload);
        return 16'(payload) + 16'(UDP_HDR_LEN);
    endfunction

    function automatic logic len_ok(input logic [10:0] payload);
        return payload <= 11'(UDP_MAX_PAYLOAD);
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; the pointer only moves when a grant is taken.
// Grant is combinational so the scheduler can register it with the header.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // set when channel 1 was granted last, giving channel 0 priority
    logic last_ch1;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_ch1 ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_ch1 <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            last_ch1 <= grant[1];
        end
    end

endmodule

// File: rtl/udp_tx_scheduler.sv
// Schedules UDP frames from two channels onto one sender with an
// inter-frame gap, length checking and a sender response timeout.
module udp_tx_scheduler
    import udp_pkg::*;
#(
    parameter int unsigned SRC_PORT       = UDP_DEF_SRC_PORT,
    parameter int unsigned DST_PORT0      = UDP_DEF_DST0,
    parameter int unsigned DST_PORT1      = UDP_DEF_DST1,
    parameter int unsigned IFG_CYCLES     = 12,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [10:0] len0,
    input  logic [10:0] len1,
    output logic [1:0]  grant,
    output logic [1:0]  done,
    output logic        err,
    output logic        tx_start,
    output logic [15:0] tx_src_port,
    output logic [15:0] tx_dst_port,
    output logic [15:0] tx_len,
    input  logic        tx_valid
);

    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  GAP_LAST = 8'(IFG_CYCLES - 1);

    tx_state_e   state;
    logic [1:0]  owner;
    logic [15:0] tcnt;
    logic [7:0]  gcnt;

    logic [1:0]  arb_gnt;
    logic        advance;
    logic [10:0] sel_len;

    assign advance = (state == ST_IDLE) && (req != 2'b00);
    assign sel_len = arb_gnt[1] ? len1 : len0;

    rr_arbiter_2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (advance),
        .grant   (arb_gnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            owner       <= 2'b00;
            tcnt        <= '0;
            gcnt        <= '0;
            grant       <= 2'b00;
            done        <= 2'b00;
            err         <= 1'b0;
            tx_start    <= 1'b0;
            tx_src_port <= '0;
            tx_dst_port <= '0;
            tx_len      <= '0;
        end else begin
            grant <= 2'b00;
            done  <= 2'b00;
            err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (advance) begin
                        grant <= arb_gnt;
                        owner <= arb_gnt;
                        tcnt  <= '0;
                        gcnt  <= '0;
                        if (len_ok(sel_len)) begin
                            tx_start    <= 1'b1;
                            tx_len      <= udp_len(sel_len);
                            tx_src_port <= 16'(SRC_PORT);
                            tx_dst_port <= arb_gnt[1] ? 16'(DST_PORT1)
                                                      : 16'(DST_PORT0);
                            state       <= ST_LAUNCH;
                        end else begin
                            // oversize payload: consume the request, send nothing
                            err   <= 1'b1;
                            state <= ST_GAP;
                        end
                    end
                end
                ST_LAUNCH: begin
                    if (tx_valid) begin
                        state <= ST_SEND;
                    end else if (tcnt >= TO_LAST) begin
                        tx_start <= 1'b0;
                        err      <= 1'b1;
                        done     <= owner;
                        state    <= ST_GAP;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                ST_SEND: begin
                    if (!tx_valid) begin
                        tx_start <= 1'b0;
                        done     <= owner;
                        state    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gcnt >= GAP_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        gcnt <= gcnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Self-checking bench for udp_tx_scheduler: vector table plus reset and
// round-robin sequences, with a grant/done scoreboard.
module tb_udp_tx_scheduler;

    localparam int IFG = 12;
    localparam int TMO = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [10:0] len0, len1;
    logic [1:0]  grant, done;
    logic        err, tx_start, tx_valid;
    logic [15:0] tx_src_port, tx_dst_port, tx_len;

    always #5 clk = ~clk;

    udp_tx_scheduler #(
        .SRC_PORT       (5000),
        .DST_PORT0      (5001),
        .DST_PORT1      (5002),
        .IFG_CYCLES     (IFG),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .len0        (len0),
        .len1        (len1),
        .grant       (grant),
        .done        (done),
        .err         (err),
        .tx_start    (tx_start),
        .tx_src_port (tx_src_port),
        .tx_dst_port (tx_dst_port),
        .tx_len      (tx_len),
        .tx_valid    (tx_valid)
    );

    typedef struct {
        logic [1:0]  grant;
        logic        err;
        logic        start;
        logic [15:0] len;
        logic [15:0] dst;
    } gexp_t;

    typedef struct {
        logic [1:0] done;
        logic       err;
    } dexp_t;

    typedef struct {
        logic [1:0]  rq;
        logic [10:0] l0;
        logic [10:0] l1;
        int          dly;
        int          hold;
        logic [1:0]  eg;
        logic [15:0] elen;
        logic        eerr;
    } vec_t;

    gexp_t gq[$];
    dexp_t dq[$];
    gexp_t ge;
    dexp_t de;
    vec_t  tbl[7];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // scoreboard: every grant and done pulse must match a queued expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (grant != 2'b00) begin
                if (gq.size() == 0) begin
                    check("unexpected_grant", grant, 2'b00);
                end else begin
                    ge = gq.pop_front();
                    check("grant", grant, ge.grant);
                    check("grant_err", err, ge.err);
                    check("grant_tx_start", tx_start, ge.start);
                    if (ge.start) begin
                        check("tx_len", tx_len, ge.len);
                        check("tx_dst_port", tx_dst_port, ge.dst);
                        check("tx_src_port", tx_src_port, 16'd5000);
                    end
                end
            end
            if (done != 2'b00) begin
                if (dq.size() == 0) begin
                    check("unexpected_done", done, 2'b00);
                end else begin
                    de = dq.pop_front();
                    check("done", done, de.done);
                    check("done_err", err, de.err);
                    check("done_tx_start", tx_start, 1'b0);
                end
            end
            if (err && grant == 2'b00 && done == 2'b00) begin
                check("spurious_err", err, 1'b0);
            end
        end
    end

    task automatic run_frame(input logic [1:0] rq, input logic [10:0] l0,
                             input logic [10:0] l1, input int dly,
                             input int hold, input logic [1:0] eg,
                             input logic [15:0] elen, input logic eerr,
                             input bit from_gap, input bit keep);
        gexp_t g;
        dexp_t d;
        int lat, k, kd, bad;
        logic [15:0] edst;
        edst = eg[1] ? 16'd5002 : 16'd5001;
        g.grant = eg;
        g.err   = eerr;
        g.start = !eerr;
        g.len   = elen;
        g.dst   = edst;
        gq.push_back(g);
        if (!eerr) begin
            d.done = eg;
            d.err  = (dly < 0);
            dq.push_back(d);
        end
        len0 = l0;
        len1 = l1;
        req  = rq;
        lat  = 0;
        bad  = 0;
        do begin
            @(negedge clk);
            lat++;
            if (tx_start && grant == 2'b00) bad++;
        end while (grant == 2'b00 && lat < 400);
        check("grant_latency", lat, from_gap ? IFG + 1 : 1);
        check("idle_tx_start", bad, 0);
        if (!keep) req = rq & ~grant;
        if (!eerr) begin
            kd = (dly < 0) ? TMO : dly + hold + 1;
            k  = 0;
            bad = 0;
            do begin
                @(posedge clk);
                #1;
                k++;
                tx_valid = (dly >= 0) && (k >= dly) && (k < dly + hold);
                if (k == 1 && !keep) begin
                    len0 = ~l0;
                    len1 = ~l1;
                end
                @(negedge clk);
                if (done == 2'b00 && (tx_start !== 1'b1 || tx_len !== elen ||
                                      tx_dst_port !== edst)) bad++;
            end while (done == 2'b00 && k < TMO + 50);
            check("done_cycle", k, kd);
            check("hdr_stable", bad, 0);
            tx_valid = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        gexp_t g;
        tbl[0] = '{2'b01, 11'd11,   11'd0,    2, 19, 2'b01, 16'h0013, 1'b0};
        tbl[1] = '{2'b10, 11'd0,    11'd100,  1,  5, 2'b10, 16'd108,  1'b0};
        tbl[2] = '{2'b01, 11'd0,    11'd7,    3,  1, 2'b01, 16'h0008, 1'b0};
        tbl[3] = '{2'b10, 11'd3,    11'd1473, 0,  0, 2'b10, 16'd0,    1'b1};
        tbl[4] = '{2'b01, 11'd1472, 11'd9,    1,  2, 2'b01, 16'd1480, 1'b0};
        tbl[5] = '{2'b10, 11'd4,    11'd1472, 2,  4, 2'b10, 16'd1480, 1'b0};
        tbl[6] = '{2'b01, 11'd5,    11'd0,   -1,  0, 2'b01, 16'd13,   1'b0};

        rst_n    = 1'b0;
        req      = 2'b00;
        len0     = '0;
        len1     = '0;
        tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_grant", grant, 2'b00);
        check("rst_done", done, 2'b00);
        check("rst_err", err, 1'b0);
        check("rst_tx_len", tx_len, 16'd0);
        check("rst_tx_dst", tx_dst_port, 16'd0);
        check("rst_tx_src", tx_src_port, 16'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_frame(tbl[i].rq, tbl[i].l0, tbl[i].l1, tbl[i].dly,
                      tbl[i].hold, tbl[i].eg, tbl[i].elen, tbl[i].eerr,
                      i != 0, 1'b0);
        end

        // reset in the middle of a frame
        repeat (IFG + 2) @(negedge clk);
        g.grant = 2'b01;
        g.err   = 1'b0;
        g.start = 1'b1;
        g.len   = 16'd58;
        g.dst   = 16'd5001;
        gq.push_back(g);
        len0 = 11'd50;
        req  = 2'b01;
        lat  = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (grant == 2'b00 && lat < 50);
        req = 2'b00;
        @(posedge clk);
        #1 tx_valid = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pre_rst_tx_start", tx_start, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_tx_start", tx_start, 1'b0);
        check("mid_rst_done", done, 2'b00);
        check("mid_rst_err", err, 1'b0);
        check("mid_rst_tx_len", tx_len, 16'd0);
        tx_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // both channels requesting: strict alternation starting with ch0
        for (int i = 0; i < 4; i++) begin
            run_frame(2'b11, 11'd20, 11'd30, 1, 3,
                      (i % 2) ? 2'b10 : 2'b01,
                      (i % 2) ? 16'd38 : 16'd28,
                      1'b0, i != 0, 1'b1);
        end
        req = 2'b00;
        repeat (IFG + 5) @(negedge clk);

        check("grant_queue_empty", gq.size(), 0);
        check("done_queue_empty", dq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/udp_tx_scheduler.md
UDP_TX_SCHEDULER -- requirements
Module: udp_tx_scheduler

Interface
REQ-001 SHALL have parameter SRC_PORT, default 5000, UDP source port for all frames.
REQ-002 SHALL have parameter DST_PORT0, default 5001, destination port for channel 0.
REQ-003 SHALL have parameter DST_PORT1, default 5002, destination port for channel 1.
REQ-004 SHALL have parameter IFG_CYCLES, default 12, idle cycles between frames (valid range 1..255).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 256, maximum wait for sender response (valid range 2..65535).
REQ-006 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-008 SHALL have port req, input, 2, per-channel frame request, held high until that channel's grant pulse.
REQ-009 SHALL have ports len0 and len1, input, 11 each, payload byte count per channel, sampled at grant.
REQ-010 SHALL have port grant, output, 2, one-hot one-cycle pulse when a channel's request is accepted.
REQ-011 SHALL have port done, output, 2, one-hot one-cycle pulse when the granted frame completes.
REQ-012 SHALL have port err, output, 1, one-cycle pulse on a length violation or sender timeout.
REQ-013 SHALL have port tx_start, output, 1, held high for the whole frame to enable the UDP sender.
REQ-014 SHALL have ports tx_src_port, tx_dst_port and tx_len, output, 16 each, header fields that stay stable while tx_start is high.
REQ-015 SHALL have port tx_valid, input, 1, byte-valid from the UDP sender.

Function
REQ-016 The FSM SHALL have the states IDLE, LAUNCH, SEND and GAP.
REQ-017 In IDLE with any req high at edge N, the block SHALL assert grant[i], tx_start=1 and the header fields at edge N+1, then enter LAUNCH.
REQ-018 Arbitration SHALL be round-robin: if both channels request, grant the channel not granted last; if only one requests, grant it regardless of the pointer.
REQ-019 The round-robin pointer SHALL update only on a grant.
REQ-020 The header fields SHALL be: tx_len = len_i + 8 as a zero-extended 16-bit value; tx_dst_port = DST_PORTi; tx_src_port = SRC_PORT.
REQ-021 len_i = 0 SHALL be legal and give tx_len = 8.
REQ-022 If len_i > 1472, the block SHALL pulse grant[i] and err together, keep tx_start low, send nothing and enter GAP with no done pulse.
REQ-023 In LAUNCH, the first cycle with tx_valid=1 SHALL move the FSM to SEND.
REQ-024 If LAUNCH lasts TIMEOUT_CYCLES cycles with tx_valid=0, tx_start SHALL drop at the next edge, err and done[i] SHALL pulse, and the FSM SHALL enter GAP.
REQ-025 In SEND, the first sampled tx_valid=0 SHALL cause tx_start=0 and done[i]=1 (one cycle) at the next edge, and entry to GAP.
REQ-026 GAP SHALL last exactly IFG_CYCLES cycles, then return to IDLE.
REQ-027 Requests arriving during LAUNCH, SEND or GAP SHALL be held pending and serviced at IDLE.
REQ-028 Within one frame, grant SHALL be at most one-hot, and done SHALL pulse exactly once for the channel granted.
REQ-029 A len change after grant SHALL not affect tx_len.
REQ-030 The timeout and IFG counters SHALL saturate and never wrap.

Reset
REQ-031 With rst_n=0 at an edge, the block SHALL set state=IDLE, tx_start=0, grant=0, done=0, err=0, the header outputs to 0, the counters to 0 and the round-robin pointer to 1 (channel 0 wins first).
REQ-032 Reset mid-frame SHALL drop tx_start at that same edge and produce no done or err pulse.

Structure
REQ-033 Package udp_pkg SHALL hold the following, shared with the UDP sender: UDP_HDR_LEN=8, UDP_MAX_PAYLOAD=1472, the default port constants and the FSM state enum.
REQ-034 A sub-module rr_arbiter_2 (2-way round-robin with registered pointer, taking req and advance, returning one-hot grant) SHALL be instantiated once.

Verification
REQ-035 The bench SHALL check: req=01, len0=11, sender raises tx_valid 2 cycles after tx_start and holds it 19 cycles -> grant=01 one cycle, tx_len=0x0013, tx_dst_port=5001, done=01 one edge after tx_valid falls, then 12 GAP cycles.
REQ-036 The bench SHALL check: req=11 held for 4 frames -> grant order ch0, ch1, ch0, ch1.
REQ-037 The bench SHALL check: len1=1473 -> grant=10 and err pulse on the same cycle, tx_start stays 0, no done.
REQ-038 The bench SHALL check: len0=0 -> tx_len=0x0008, normal completion.
REQ-039 The bench SHALL check: tx_valid never rises -> tx_start drops after 256 LAUNCH cycles, err=1 and done=01 pulse together, GAP follows.
REQ-040 The bench SHALL check: rst_n=0 during SEND -> tx_start=0 at that edge; after release with req=11, ch0 is granted first.
